mux_share_arbiter: RTL and testbench
====================================

// Module: mux_share_arbiter
// PURPOSE
//   Shares the N-bit 2:1 select datapath between two requesters, A and B.
//   Each requester uses a valid/ready handshake. A round-robin FSM picks the
//   requester, drives the mux select and holds the winning word in a 1-entry
//   output register with its own valid/ready handshake to the consumer.
//   Sits between the two producers and the downstream stage. One per
//   shared-mux instance.
// PARAMETERS
//   N      8   data width of a_data, b_data and out_data
//   CNT_W  16  width of the per-requester accepted-transfer counters
// PORTS
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   a_valid   in   1      requester A has a word on a_data
//   a_data    in   N      requester A data (mux input 0)
//   a_ready   out  1      A word is accepted this cycle
//   b_valid   in   1      requester B has a word on b_data
//   b_data    in   N      requester B data (mux input 1)
//   b_ready   out  1      B word is accepted this cycle
//   sel       out  1      registered source of out_data: 0 = A, 1 = B
//   out_valid out  1      out_data holds a valid word
//   out_data  out  N      registered mux output
//   out_ready in   1      consumer accepts out_data this cycle
//   cnt_a     out  CNT_W  number of A transfers accepted
//   cnt_b     out  CNT_W  number of B transfers accepted
// BEHAVIOUR
//   Clock and reset
//   - Single clock domain. rst_n is asynchronous and active-low.
//   - Reset values: out_valid=0, out_data=0, sel=0, cnt_a=0, cnt_b=0,
//     last=1 (internal round-robin pointer), FSM=EMPTY.
//   Arbitration (combinational, every cycle)
//   - Only A valid: grant A. Only B valid: grant B. Neither valid: no grant.
//   - Both valid: grant the requester that is not `last`. After reset, A wins.
//   Load and ready
//   - can_load = (FSM==EMPTY) | (out_ready & out_valid).
//   - a_ready = grant_A & can_load. b_ready = grant_B & can_load.
//   - Both ready outputs are never high in the same cycle.
//   - a_ready and b_ready depend combinationally on valid and out_ready.
//   - A requester's data is sampled only on its own valid & ready cycle.
//   FSM
//   - EMPTY: on a grant, load out_data=granted data, set sel=granted source,
//     set last=granted source, go to FULL. Otherwise stay EMPTY.
//   - FULL, out_ready=1: word is consumed. On a grant, reload in the same
//     cycle and stay FULL. With no grant, go to EMPTY (out_valid drops).
//   - FULL, out_ready=0: hold out_data and sel stable. No ready is asserted.
//   - out_valid = (FSM==FULL).
//   Latency and throughput
//   - Accepted word appears on out_data one cycle after its handshake.
//   - Sustained throughput is 1 word per cycle when out_ready stays high.
//   Select output
//   - sel changes only on a load. It keeps its value when the FSM goes to EMPTY.
//   Counters
//   - cnt_a increments on a_valid & a_ready; cnt_b increments on b_valid & b_ready.
//   - Both counters wrap modulo 2^CNT_W with no saturation and no flag.
//   Boundary conditions
//   - A request arriving in the same cycle a word drains is served with no
//     bubble.
//   - A valid held while not granted must be kept high by the producer.
//     The arbiter has no drop path.
//   - Reset mid-operation: out_valid falls immediately (asynchronous) and the
//     held word is discarded. Counters and pointer return to reset values.
// TESTING
//   1 Reset: rst_n=0 with both valids high -> out_valid=0, a_ready=b_ready=0,
//     cnt_a=cnt_b=0, sel=0.
//   2 A only: a_data=8'h01 valid 1 cycle, out_ready=1 -> next cycle
//     out_data=8'h01, sel=0, cnt_a=1.
//   3 Contention: a_data=8'h01, b_data=8'h02 both valid 4 cycles,
//     out_ready=1 -> out_data sequence 01,02,01,02; sel 0,1,0,1;
//     cnt_a=cnt_b=2.
//   4 Backpressure: out FULL with 8'h02, out_ready=0 for 3 cycles ->
//     out_data and sel stable, a_ready=b_ready=0. Then out_ready=1 ->
//     pending word loads the same cycle.
//   5 Counter wrap: CNT_W=4, 16 A transfers -> cnt_a returns to 0.
//   6 Async reset while FULL and stalled -> out_valid=0 before the next clock
//     edge; after release, the first contention grants A.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter
// Round-robin arbiter that shares one N-bit 2:1 select path between two
// valid/ready requesters. The winning word is held in a 1-entry output
// register that has its own valid/ready handshake to the consumer.
module mux_share_arbiter #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [N-1:0]     a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [N-1:0]     b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state;
    logic   last;       // source of the most recent load: 0 = A, 1 = B
    logic   grant_a;
    logic   grant_b;
    logic   can_load;

    assign out_valid = (state == FULL);

    // Round-robin grant and handshake readies; readies are held low during reset
    always_comb begin
        grant_a  = a_valid & (~b_valid | last);
        grant_b  = b_valid & (~a_valid | ~last);
        can_load = (state == EMPTY) | (out_ready & out_valid);
        a_ready  = rst_n & grant_a & can_load;
        b_ready  = rst_n & grant_b & can_load;
    end

    // Output-register FSM: load on a grant, drain to EMPTY when consumed with no new grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_data <= '0;
            sel      <= 1'b0;
            last     <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (a_ready || b_ready) begin
                        out_data <= b_ready ? b_data : a_data;
                        sel      <= b_ready;
                        last     <= b_ready;
                        state    <= FULL;
                    end
                end
                FULL: begin
                    if (a_ready || b_ready) begin
                        out_data <= b_ready ? b_data : a_data;
                        sel      <= b_ready;
                        last     <= b_ready;
                        state    <= FULL;
                    end else if (out_ready) begin
                        state    <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Accepted-transfer counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_valid && a_ready) cnt_a <= cnt_a + 1'b1;
            if (b_valid && b_ready) cnt_b <= cnt_b + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: directed vectors, literal expectations and a
// behavioural model checked on every falling clock edge.
module tb_mux_share_arbiter;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             a_valid = 1'b0;
    logic [N-1:0]     a_data = '0;
    logic             a_ready;
    logic             b_valid = 1'b0;
    logic [N-1:0]     b_data = '0;
    logic             b_ready;
    logic             sel;
    logic             out_valid;
    logic [N-1:0]     out_data;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    int tests = 0;
    int fails = 0;

    mux_share_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one held word, who loaded last, and transfer totals
    bit       m_full = 0;
    int       m_data = 0;
    int       m_sel  = 0;
    int       m_last = 1;
    int       m_cnta = 0;
    int       m_cntb = 0;

    always @(negedge clk) begin
        int  winner;
        bit  room;
        bit  ea, eb;
        if (!rst_n) begin
            chk("rst out_valid", out_valid, 0);
            chk("rst a_ready", a_ready, 0);
            chk("rst b_ready", b_ready, 0);
            chk("rst out_data", out_data, 0);
            chk("rst sel", sel, 0);
            chk("rst cnt_a", cnt_a, 0);
            chk("rst cnt_b", cnt_b, 0);
            m_full = 0; m_data = 0; m_sel = 0; m_last = 1; m_cnta = 0; m_cntb = 0;
        end else begin
            // who would win if the word could be taken: the other one than last
            if (a_valid && b_valid) winner = (m_last == 1) ? 0 : 1;
            else if (a_valid)       winner = 0;
            else if (b_valid)       winner = 1;
            else                    winner = -1;
            room = !m_full || out_ready;
            ea = room && (winner == 0);
            eb = room && (winner == 1);
            chk("mdl out_valid", out_valid, m_full);
            chk("mdl out_data", out_data, m_data);
            chk("mdl sel", sel, m_sel);
            chk("mdl cnt_a", cnt_a, m_cnta % 16);
            chk("mdl cnt_b", cnt_b, m_cntb % 16);
            chk("mdl a_ready", a_ready, ea);
            chk("mdl b_ready", b_ready, eb);
            if (ea || eb) begin
                m_data = ea ? int'(a_data) : int'(b_data);
                m_sel  = winner;
                m_last = winner;
                m_full = 1;
                if (ea) m_cnta++; else m_cntb++;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
        end
    end

    logic [7:0] seq_d [4];
    logic       seq_s [4];
    logic [7:0] exp_d [4];
    logic       exp_s [4];

    initial begin
        exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h01; exp_d[3] = 8'h02;
        exp_s[0] = 1'b0;  exp_s[1] = 1'b1;  exp_s[2] = 1'b0;  exp_s[3] = 1'b1;

        // 1: reset with both requesters valid
        a_valid = 1; b_valid = 1; a_data = 8'h11; b_data = 8'h22; out_ready = 1;
        step(); step();
        chk("t1 out_valid", out_valid, 0);
        chk("t1 a_ready", a_ready, 0);
        chk("t1 b_ready", b_ready, 0);
        chk("t1 cnt_a", cnt_a, 0);
        chk("t1 sel", sel, 0);
        a_valid = 0; b_valid = 0;
        rst_n = 1;
        step();

        // 2: single A transfer
        a_valid = 1; a_data = 8'h01; out_ready = 1;
        step();
        a_valid = 0;
        chk("t2 out_data", out_data, 8'h01);
        chk("t2 sel", sel, 0);
        chk("t2 cnt_a", cnt_a, 1);
        chk("t2 out_valid", out_valid, 1);
        step();
        chk("t2 drained", out_valid, 0);

        // 3: contention from a fresh pointer
        rst_n = 0; step(); rst_n = 1; step();
        a_valid = 1; b_valid = 1; a_data = 8'h01; b_data = 8'h02; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            seq_d[i] = out_data;
            seq_s[i] = sel;
        end
        // 4 starts here: stall with 02 held
        a_valid = 0; b_valid = 0; out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3 data%0d", i), seq_d[i], exp_d[i]);
            chk($sformatf("t3 sel%0d", i), seq_s[i], exp_s[i]);
        end
        chk("t3 cnt_a", cnt_a, 2);
        chk("t3 cnt_b", cnt_b, 2);

        // 4: backpressure with both requesters pending
        a_valid = 1; b_valid = 1; a_data = 8'h03; b_data = 8'h04;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4 a_ready stalled", a_ready, 0);
            chk("t4 b_ready stalled", b_ready, 0);
            step();
            chk("t4 hold data", out_data, 8'h02);
            chk("t4 hold sel", sel, 1);
            chk("t4 hold valid", out_valid, 1);
        end
        out_ready = 1;
        #1;
        chk("t4 a_ready release", a_ready, 1);
        chk("t4 b_ready release", b_ready, 0);
        step();
        a_valid = 0; b_valid = 0;
        chk("t4 reload data", out_data, 8'h03);
        chk("t4 reload sel", sel, 0);
        step();

        // 5: counter wrap at CNT_W=4
        rst_n = 0; step(); rst_n = 1; step();
        a_valid = 1; a_data = 8'h5a; out_ready = 1;
        for (int i = 0; i < 15; i++) step();
        chk("t5 cnt_a 15", cnt_a, 15);
        step();
        a_valid = 0;
        chk("t5 cnt_a wrap", cnt_a, 0);
        step();

        // 6: asynchronous reset while full and stalled
        a_valid = 1; b_valid = 1; a_data = 8'h07; b_data = 8'h08; out_ready = 0;
        step();
        step();
        chk("t6 full before rst", out_valid, 1);
        #2;
        rst_n = 0;
        #1;
        chk("t6 async out_valid", out_valid, 0);
        chk("t6 async cnt_a", cnt_a, 0);
        step();
        rst_n = 1;
        a_data = 8'h05; b_data = 8'h06; out_ready = 1;
        #1;
        chk("t6 first grant A", a_ready, 1);
        chk("t6 first grant not B", b_ready, 0);
        step();
        chk("t6 out_data", out_data, 8'h05);
        chk("t6 sel", sel, 0);
        step();
        chk("t6 second grant B", out_data, 8'h06);
        a_valid = 0; b_valid = 0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
